im_loader: RTL and testbench
============================

# im_loader

Boot-time controller that sequences the CPU's instruction-memory load port. It accepts a stream of instruction words over a valid/ready handshake and writes them into consecutive instruction-memory locations. While loading, it holds the pipeline frozen; on completion it releases the CPU. Its outputs drive the CPU's `im_add`/`im_data`/`im_en`/`im_rd_wr` inputs directly.

## Interface
- `NMEM`, 20: instruction-memory depth in words; legal load range.
- `CNT_W`, 8: width of word-count fields; requires 2^CNT_W > NMEM.
- `clk`  in  1  sole clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins a load; honoured in IDLE, DONE, ERR only.
- `base`  in  CNT_W  first word index written; sampled on `start`.
- `count`  in  CNT_W  number of words to load; sampled on `start`.
- `s_valid`  in  1  stream word valid.
- `s_data`  in  32  stream word.
- `s_ready`  out  1  loader accepts `s_data` this cycle.
- `im_add`  out  32  byte address to the instruction memory, = word index × 4.
- `im_data`  out  32  write data to the instruction memory.
- `im_en`  out  1  instruction-memory port access strobe.
- `im_rd_wr`  out  1  1 = write, 0 = read.
- `im_rdata`  in  32  instruction-memory read data, valid 1 cycle after a read strobe (used only with the readback feature).
- `cpu_hold`  out  1  freezes the CPU PC and pipeline while 1.
- `busy`  out  1  in LOAD or VERIFY.
- `done`  out  1  last load completed successfully.
- `err`  out  1  last load rejected or failed verification.

## Operation
- States: IDLE, LOAD, VERIFY (feature-dependent), DONE, ERR.
- IDLE: `cpu_hold`=1, `s_ready`=0. On `start`:
  - If `count`==0 or `base`+`count` > NMEM (computed at CNT_W+1 bits, no wrap), go to ERR.
  - Otherwise latch `addr`=`base`, `remaining`=`count`, clear `csum`, and go to LOAD.
- LOAD: `s_ready`=1 and `busy`=1. On each beat (`s_valid`&`s_ready`):
  - Register a write on the next cycle: `im_en`=1, `im_rd_wr`=1, `im_add`=`addr`×4, `im_data`=`s_data`.
  - Update `csum` ^= `s_data`, `addr`++, `remaining`--.
  - Without a beat, `im_en`=0 on the next cycle.
  - On the beat with `remaining`==1, `s_ready` drops the next cycle and the state goes to VERIFY (feature on) or DONE.
- DONE: `done`=1, `cpu_hold`=0, `busy`=0. Held until `start` or `rst`.
- ERR: `err`=1, `cpu_hold`=1. Held until `start` or `rst`.
- `start` in DONE or ERR clears `done`/`err`, reasserts `cpu_hold` the next cycle, and applies the IDLE range checks. `start` in LOAD or VERIFY is ignored.
- `rst` mid-operation returns to IDLE with all outputs at reset values. Memory contents already written are left as-is, and no partial `done` is signalled.
- Reset values: `s_ready` 0, `im_en` 0, `im_rd_wr` 0, `im_add` 0, `im_data` 0, `cpu_hold` 1, `busy` 0, `done` 0, `err` 0. Internal `addr`, `remaining`, `csum` are all 0.

## Timing
- All outputs are registered.
- Handshake to the write appearing on `im_*`: 1 cycle. Back-to-back beats produce back-to-back writes.
- `s_ready` is combinationally independent of `s_valid`. A word is consumed only when both are high.
- N-word load with continuous `s_valid`, feature off: `start` at cycle 0, LOAD from cycle 1, last write at cycle N+1, `done`=1 and `cpu_hold`=0 at cycle N+2.
- The last write is committed no later than the cycle `cpu_hold` falls.

## Configuration
- Macro: `IM_LOADER_READBACK_EN`.
- Defined:
  - After LOAD, VERIFY issues reads to `base`..`base`+`count`-1, one per cycle (`im_en`=1, `im_rd_wr`=0).
  - Each `im_rdata` is sampled 1 cycle after its read and XOR-folded into `rsum`.
  - One cycle after the last `im_rdata` sample, `rsum`==`csum` leads to DONE; a mismatch leads to ERR.
  - This adds `count`+2 cycles to the load.
- Undefined: the VERIFY state and `rsum` are not built, `im_rdata` is ignored, and LOAD goes directly to DONE.

## Test plan
- Reset, then idle: `cpu_hold`=1, `im_en`=0, `done`=0, `err`=0, held for 10 cycles without `start`.
- `start` with `base`=0, `count`=3, words 0x20010005/0x20020007/0x00221820, `s_valid` held high:
  - Writes to addresses 0x0, 0x4, 0x8 on consecutive cycles.
  - `done`=1 and `cpu_hold`=0 at cycle 5 (feature off).
- Same load with `s_valid` toggling every other cycle: writes occur only after accepted beats, and the data order is preserved.
- Range checks:
  - `start` with `base`=18, `count`=3 (NMEM=20) goes to ERR the next cycle, with no `im_en` pulse.
  - `count`=0 also goes to ERR.
- `rst` asserted after 2 of 4 beats: the next cycle shows IDLE reset values, and a subsequent `start` reloads from `base`.
- Feature on:
  - Model `im_rdata` returning stored data: 3 reads follow the writes, then `done`.
  - Corrupt one read word (bit 0 flipped): ERR with `cpu_hold`=1.

Source files
------------

// File: rtl/im_loader_if.sv
// im_loader_if: stream-in handshake plus instruction-memory port bundle for im_loader.
// master = loader side, slave = stream source / memory side.
interface im_loader_if;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_ready;
  logic [31:0] im_add;
  logic [31:0] im_data;
  logic        im_en;
  logic        im_rd_wr;
  logic [31:0] im_rdata;

  modport master (
    input  s_valid, s_data, im_rdata,
    output s_ready, im_add, im_data, im_en, im_rd_wr
  );

  modport slave (
    output s_valid, s_data, im_rdata,
    input  s_ready, im_add, im_data, im_en, im_rd_wr
  );
endinterface

// File: rtl/im_loader.sv
// im_loader: boot-time instruction-memory loader; streams words into IM while holding the CPU.
// Define IM_LOADER_READBACK_EN to build the readback/checksum VERIFY phase.
module im_loader #(
  parameter int unsigned NMEM  = 20,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [CNT_W-1:0] base_i,
  input  logic [CNT_W-1:0] count_i,
  im_loader_if.master      bus,
  output logic             cpu_hold_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);
  localparam int unsigned SUM_W = CNT_W + 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_VERIFY, S_DONE, S_ERR} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] addr_q, addr_d, remaining_q, remaining_d;
  logic             s_ready_q, s_ready_d, im_en_q, im_en_d, im_rd_wr_q, im_rd_wr_d;
  logic [31:0]      im_add_q, im_add_d, im_data_q, im_data_d;
  logic             cpu_hold_q, cpu_hold_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [SUM_W-1:0] end_idx;
  logic             range_ok, beat;
`ifdef IM_LOADER_READBACK_EN
  logic [31:0]      csum_q, csum_d, rsum_q, rsum_d;
  logic [CNT_W-1:0] base_q, base_d, count_q, count_d, rx_cnt_q, rx_cnt_d;
  logic             rvld_q, rvld_d;
`endif

  // Range check at CNT_W+1 bits so base+count cannot wrap past NMEM.
  assign end_idx  = SUM_W'(base_i) + SUM_W'(count_i);
  assign range_ok = (count_i != '0) && (end_idx <= SUM_W'(NMEM));
  assign beat     = (state_q == S_LOAD) && bus.s_valid && s_ready_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    im_en_d     = 1'b0;
    im_rd_wr_d  = im_rd_wr_q;
    im_add_d    = im_add_q;
    im_data_d   = im_data_q;
`ifdef IM_LOADER_READBACK_EN
    csum_d      = csum_q;
    rsum_d      = rsum_q;
    base_d      = base_q;
    count_d     = count_q;
    rx_cnt_d    = rx_cnt_q;
    rvld_d      = im_en_q && !im_rd_wr_q;
`endif
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start_i) begin
          if (range_ok) begin
            state_d     = S_LOAD;
            addr_d      = base_i;
            remaining_d = count_i;
`ifdef IM_LOADER_READBACK_EN
            csum_d      = '0;
            base_d      = base_i;
            count_d     = count_i;
`endif
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_LOAD: begin
        if (beat) begin
          im_en_d     = 1'b1;
          im_rd_wr_d  = 1'b1;
          im_add_d    = 32'(addr_q) << 2;
          im_data_d   = bus.s_data;
          addr_d      = addr_q + CNT_W'(1);
          remaining_d = remaining_q - CNT_W'(1);
`ifdef IM_LOADER_READBACK_EN
          csum_d      = csum_q ^ bus.s_data;
`endif
          if (remaining_q == CNT_W'(1)) begin
`ifdef IM_LOADER_READBACK_EN
            state_d     = S_VERIFY;
            addr_d      = base_q;
            remaining_d = count_q;
            rx_cnt_d    = '0;
            rsum_d      = '0;
`else
            state_d     = S_DONE;
`endif
          end
        end
      end
      S_VERIFY: begin
`ifdef IM_LOADER_READBACK_EN
        // addr/remaining are reused as the read-issue cursor.
        if (remaining_q != '0) begin
          im_en_d     = 1'b1;
          im_rd_wr_d  = 1'b0;
          im_add_d    = 32'(addr_q) << 2;
          addr_d      = addr_q + CNT_W'(1);
          remaining_d = remaining_q - CNT_W'(1);
        end
        if (rvld_q) begin
          rsum_d   = rsum_q ^ bus.im_rdata;
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
        if (rx_cnt_q == count_q) begin
          state_d = (rsum_q == csum_q) ? S_DONE : S_ERR;
        end
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase

    // done lags a LOAD->DONE step by one cycle so the last write lands before release.
    s_ready_d  = (state_d == S_LOAD);
    busy_d     = (state_d == S_LOAD) || (state_d == S_VERIFY);
    done_d     = (state_d == S_DONE) && (state_q != S_LOAD);
    err_d      = (state_d == S_ERR);
    cpu_hold_d = !done_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      s_ready_q   <= 1'b0;
      im_en_q     <= 1'b0;
      im_rd_wr_q  <= 1'b0;
      im_add_q    <= '0;
      im_data_q   <= '0;
      cpu_hold_q  <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef IM_LOADER_READBACK_EN
      csum_q      <= '0;
      rsum_q      <= '0;
      base_q      <= '0;
      count_q     <= '0;
      rx_cnt_q    <= '0;
      rvld_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      s_ready_q   <= s_ready_d;
      im_en_q     <= im_en_d;
      im_rd_wr_q  <= im_rd_wr_d;
      im_add_q    <= im_add_d;
      im_data_q   <= im_data_d;
      cpu_hold_q  <= cpu_hold_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
`ifdef IM_LOADER_READBACK_EN
      csum_q      <= csum_d;
      rsum_q      <= rsum_d;
      base_q      <= base_d;
      count_q     <= count_d;
      rx_cnt_q    <= rx_cnt_d;
      rvld_q      <= rvld_d;
`endif
    end
  end

  assign bus.s_ready  = s_ready_q;
  assign bus.im_en    = im_en_q;
  assign bus.im_rd_wr = im_rd_wr_q;
  assign bus.im_add   = im_add_q;
  assign bus.im_data  = im_data_q;
  assign cpu_hold_o   = cpu_hold_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
endmodule

// File: tb/tb_im_loader.sv
// tb_im_loader: scoreboard bench for im_loader with a behavioural instruction memory.
// Readback scenarios are included when IM_LOADER_READBACK_EN is defined.
module tb_im_loader;
  localparam int unsigned NMEM  = 20;
  localparam int unsigned CNT_W = 8;
`ifdef IM_LOADER_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic       clk     = 1'b0;
  logic       rst     = 1'b1;
  logic       start_i = 1'b0;
  logic [7:0] base_i  = 8'h0;
  logic [7:0] count_i = 8'h0;
  logic       cpu_hold_o, busy_o, done_o, err_o;

  im_loader_if bus();

  im_loader #(.NMEM(NMEM), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .base_i     (base_i),
    .count_i    (count_i),
    .bus        (bus),
    .cpu_hold_o (cpu_hold_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o)
  );

  always #5 clk = ~clk;

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [31:0] mem [0:31];
  logic [5:0]  corrupt_idx = 6'h3f;
  logic [31:0] wbuf [0:7];
  logic [95:0] wq [$];
  logic [63:0] rq [$];

  // Instruction memory: writes commit on the edge, reads return one cycle later.
  always @(posedge clk) begin
    if (bus.im_en && bus.im_rd_wr) mem[bus.im_add[6:2]] <= bus.im_data;
    if (bus.im_en && !bus.im_rd_wr)
      bus.im_rdata <= mem[bus.im_add[6:2]] ^
                      (({1'b0, bus.im_add[6:2]} == corrupt_idx) ? 32'h1 : 32'h0);
  end

  task automatic run_load(input int unsigned base, input int unsigned cnt, input bit toggle,
                          input int unsigned abort_at, input bit expect_err);
    int unsigned idx, last_beat, nwr, nrd, exp_t;
    bit          finished;
    logic [95:0] wexp;
    logic [63:0] rexp;
    idx = 0; last_beat = 0; nwr = 0; nrd = 0; finished = 1'b0;
    wq.delete(); rq.delete();
    @(negedge clk);
    start_i = 1'b1; base_i = 8'(base); count_i = 8'(cnt);
    for (int unsigned t = 1; t <= 300; t++) begin
      @(negedge clk);
      start_i = 1'b0;
      if (t == 1) begin
        n_cmp++;
        if ({busy_o, done_o, err_o, cpu_hold_o} !== 4'b1001) begin
          n_fail++;
          $display("FAIL load_entry base=%0d: busy/done/err/hold=%b want 1001", base,
                   {busy_o, done_o, err_o, cpu_hold_o});
        end
      end
      if (bus.im_en === 1'b1 && bus.im_rd_wr === 1'b1) begin
        nwr++; n_cmp++;
        if (wq.size() == 0) begin
          n_fail++;
          $display("FAIL write_unexpected t=%0d: add=%h data=%h, none expected", t, bus.im_add, bus.im_data);
        end else begin
          wexp = wq.pop_front();
          if ({t, bus.im_add, bus.im_data} !== wexp) begin
            n_fail++;
            $display("FAIL write t/add/data: got %0d/%h/%h want %0d/%h/%h", t, bus.im_add, bus.im_data,
                     wexp[95:64], wexp[63:32], wexp[31:0]);
          end
        end
      end
      if (bus.im_en === 1'b1 && bus.im_rd_wr === 1'b0) begin
        nrd++; n_cmp++;
        if (rq.size() == 0) begin
          n_fail++;
          $display("FAIL read_unexpected t=%0d: add=%h, none expected", t, bus.im_add);
        end else begin
          rexp = rq.pop_front();
          if ({t, bus.im_add} !== rexp) begin
            n_fail++;
            $display("FAIL read t/add: got %0d/%h want %0d/%h", t, bus.im_add, rexp[63:32], rexp[31:0]);
          end
        end
      end
      if (last_beat != 0 && idx == cnt && t == last_beat + 1) begin
        n_cmp++;
        if (bus.s_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL s_ready_drop t=%0d: got %b want 0", t, bus.s_ready);
        end
      end
      if (abort_at != 0 && t == abort_at) begin
        rst = 1'b1; bus.s_valid = 1'b0; finished = 1'b1;
        n_cmp++;
        if (nwr !== abort_at - 1 || wq.size() != 0) begin
          n_fail++;
          $display("FAIL abort_writes: got %0d writes (%0d pending) want %0d", nwr, wq.size(), abort_at - 1);
        end
        break;
      end
      if (done_o === 1'b1 || err_o === 1'b1) begin
        exp_t = RB ? last_beat + cnt + 4 : last_beat + 2;
        n_cmp++;
        if (t !== exp_t) begin
          n_fail++;
          $display("FAIL finish_cycle base=%0d cnt=%0d: got %0d want %0d", base, cnt, t, exp_t);
        end
        n_cmp++;
        if ({done_o, err_o, cpu_hold_o} !== (expect_err ? 3'b011 : 3'b100)) begin
          n_fail++;
          $display("FAIL finish_flags done/err/hold: got %b want %b", {done_o, err_o, cpu_hold_o},
                   expect_err ? 3'b011 : 3'b100);
        end
        n_cmp++;
        if (nwr !== cnt || nrd !== (RB ? cnt : 0) || wq.size() != 0 || rq.size() != 0) begin
          n_fail++;
          $display("FAIL access_count: got wr=%0d rd=%0d want wr=%0d rd=%0d", nwr, nrd, cnt, RB ? cnt : 0);
        end
        finished = 1'b1;
        break;
      end
      if (idx < cnt && (!toggle || t[0])) begin
        bus.s_valid = 1'b1;
        bus.s_data  = wbuf[idx];
        if (bus.s_ready === 1'b1) begin
          wq.push_back({t + 1, 32'((base + idx) * 4), wbuf[idx]});
          idx++;
          last_beat = t;
          if (idx == cnt && RB)
            for (int unsigned k = 0; k < cnt; k++) rq.push_back({t + 2 + k, 32'((base + k) * 4)});
        end
      end else begin
        bus.s_valid = 1'b0;
      end
    end
    bus.s_valid = 1'b0;
    if (!finished) begin
      n_cmp++; n_fail++;
      $display("FAIL load_timeout base=%0d cnt=%0d: no done/err within 300 cycles", base, cnt);
    end
  endtask

  task automatic check_reset_values(input string tag);
    n_cmp++;
    if ({bus.s_ready, bus.im_en, bus.im_rd_wr, bus.im_add, bus.im_data, cpu_hold_o, busy_o, done_o, err_o}
        !== {3'b000, 64'h0, 4'b1000}) begin
      n_fail++;
      $display("FAIL %s: rdy/en/rw=%b add=%h data=%h hold/busy/done/err=%b want 000 0 0 1000", tag,
               {bus.s_ready, bus.im_en, bus.im_rd_wr}, bus.im_add, bus.im_data,
               {cpu_hold_o, busy_o, done_o, err_o});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values("reset_values");
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({cpu_hold_o, bus.im_en, done_o, err_o} !== 4'b1000) begin
        n_fail++;
        $display("FAIL idle_hold cycle %0d: hold/en/done/err=%b want 1000", i,
                 {cpu_hold_o, bus.im_en, done_o, err_o});
      end
    end
  endtask

  task automatic test_basic();
    wbuf[0] = 32'h20010005; wbuf[1] = 32'h20020007; wbuf[2] = 32'h00221820;
    run_load(0, 3, 1'b0, 0, 1'b0);
  endtask

  task automatic test_toggle();
    wbuf[0] = 32'h20010005; wbuf[1] = 32'h20020007; wbuf[2] = 32'h00221820;
    run_load(0, 3, 1'b1, 0, 1'b0);
  endtask

  task automatic test_range(input int unsigned base, input int unsigned cnt);
    @(negedge clk);
    start_i = 1'b1; base_i = 8'(base); count_i = 8'(cnt);
    @(negedge clk);
    start_i = 1'b0;
    n_cmp++;
    if ({err_o, done_o, busy_o, cpu_hold_o, bus.im_en, bus.s_ready} !== 6'b100100) begin
      n_fail++;
      $display("FAIL range_err base=%0d cnt=%0d: err/done/busy/hold/en/rdy=%b want 100100", base, cnt,
               {err_o, done_o, busy_o, cpu_hold_o, bus.im_en, bus.s_ready});
    end
    @(negedge clk);
    n_cmp++;
    if ({err_o, bus.im_en} !== 2'b10) begin
      n_fail++;
      $display("FAIL range_hold base=%0d cnt=%0d: err/en=%b want 10", base, cnt, {err_o, bus.im_en});
    end
  endtask

  task automatic test_boundary();
    wbuf[0] = 32'hA5A50001; wbuf[1] = 32'h5A5A0002; wbuf[2] = 32'hFFFF0003;
    run_load(17, 3, 1'b0, 0, 1'b0);
  endtask

  task automatic test_mid_reset();
    wbuf[0] = 32'h11111111; wbuf[1] = 32'h22222222; wbuf[2] = 32'h33333333; wbuf[3] = 32'h44444444;
    run_load(4, 4, 1'b0, 3, 1'b0);
    @(negedge clk);
    check_reset_values("mid_reset_values");
    rst = 1'b0;
    run_load(4, 4, 1'b0, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) wbuf[i] = 32'hC0DE0000 + 32'(i * 3);
    run_load(10, 5, 1'b0, 0, 1'b0);
    run_load(15, 5, 1'b1, 0, 1'b0);
  endtask

`ifdef IM_LOADER_READBACK_EN
  task automatic test_readback_corrupt();
    wbuf[0] = 32'h20010005; wbuf[1] = 32'h20020007; wbuf[2] = 32'h00221820;
    corrupt_idx = 6'd1;
    run_load(0, 3, 1'b0, 0, 1'b1);
    corrupt_idx = 6'h3f;
    run_load(0, 3, 1'b0, 0, 1'b0);
  endtask
`endif

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = 32'h0;
    test_reset();
    test_basic();
    test_toggle();
    test_range(18, 3);
    test_range(5, 0);
    test_boundary();
    test_mid_reset();
    test_back_to_back();
`ifdef IM_LOADER_READBACK_EN
    test_readback_corrupt();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
